// File: rtl/eca_pkg.sv
// Shared types for the elementary cellular automaton engine: boundary modes and control states.
package eca_pkg;

    typedef enum logic [1:0] {
        BND_WRAP   = 2'b00,
        BND_ZERO   = 2'b01,
        BND_ONE    = 2'b10,
        BND_MIRROR = 2'b11
    } bnd_mode_e;

    typedef enum logic [0:0] {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } eca_state_e;

endpackage

// File: rtl/eca_next_gen.sv
// Combinational next-generation function: applies an 8-bit Wolfram rule to every cell,
// resolving the out-of-range edge neighbours according to the boundary mode.
module eca_next_gen
    import eca_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0]       rule_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] next_o
);

    logic edge_l; // stands in for cur[WIDTH]
    logic edge_r; // stands in for cur[-1]

    always_comb begin
        edge_l = 1'b0;
        edge_r = 1'b0;
        unique case (bnd_mode_e'(mode_i))
            BND_WRAP: begin
                edge_l = cur_i[0];
                edge_r = cur_i[WIDTH-1];
            end
            BND_ZERO: begin
                edge_l = 1'b0;
                edge_r = 1'b0;
            end
            BND_ONE: begin
                edge_l = 1'b1;
                edge_r = 1'b1;
            end
            BND_MIRROR: begin
                edge_l = cur_i[WIDTH-1];
                edge_r = cur_i[0];
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic lft;
        logic rgt;
        if (i == WIDTH - 1) begin : g_ledge
            assign lft = edge_l;
        end else begin : g_lin
            assign lft = cur_i[i+1];
        end
        if (i == 0) begin : g_redge
            assign rgt = edge_r;
        end else begin : g_rin
            assign rgt = cur_i[i-1];
        end
        assign next_o[i] = rule_i[{lft, cur_i[i], rgt}];
    end

endmodule

// File: rtl/eca_engine.sv
// Elementary cellular automaton engine with prescaled free-run, single-step and seed loading.
// Optional ECA_HALT_ON_STABLE_EN: free-run parks in pause when a fixed point is reached.
module eca_engine
    import eca_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rule_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] period_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             load_ready_o,
    output logic [WIDTH-1:0] cur_o,
    output logic [GEN_W-1:0] gen_count_o,
    output logic             tick_o,
    output logic             stable_o
);

    localparam logic [GEN_W-1:0] GenOne = GEN_W'(1);
    localparam logic [DIV_W-1:0] PreOne = DIV_W'(1);

    eca_state_e       state_q, state_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] next_gen;
    logic             load_fire;

    eca_next_gen #(
        .WIDTH (WIDTH)
    ) u_next_gen (
        .rule_i (rule_i),
        .mode_i (mode_i),
        .cur_i  (cur_q),
        .next_o (next_gen)
    );

    assign stable_o     = (next_gen == cur_q);
    assign load_ready_o = (state_q == ST_PAUSE);
    assign load_fire    = load_valid_i & load_ready_o;
    assign cur_o        = cur_q;
    assign gen_count_o  = gen_q;
    assign tick_o       = tick_q;

`ifdef ECA_HALT_ON_STABLE_EN
    // Set when free-run parks on a fixed point; re-arms on run low or a fresh load.
    logic halt_q, halt_d;
`endif

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cur_d   = cur_q;
        gen_d   = gen_q;
        tick_d  = 1'b0;
`ifdef ECA_HALT_ON_STABLE_EN
        halt_d  = halt_q;
        if (!run_i || load_fire) begin
            halt_d = 1'b0;
        end
`endif
        unique case (state_q)
            ST_PAUSE: begin
                if (load_fire) begin
                    cur_d = load_data_i;
                    gen_d = '0;
                    pre_d = '0;
                end else if (step_i) begin
                    cur_d  = next_gen;
                    gen_d  = gen_q + GenOne;
                    tick_d = 1'b1;
                end
`ifdef ECA_HALT_ON_STABLE_EN
                if (run_i && (!halt_q || load_fire)) begin
`else
                if (run_i) begin
`endif
                    state_d = ST_RUN;
                    pre_d   = '0;
                end
            end
            ST_RUN: begin
                if (!run_i) begin
                    state_d = ST_PAUSE;
                end else if (pre_q == period_i) begin
                    pre_d = '0;
`ifdef ECA_HALT_ON_STABLE_EN
                    if (stable_o) begin
                        state_d = ST_PAUSE;
                        halt_d  = 1'b1;
                    end else begin
                        cur_d  = next_gen;
                        gen_d  = gen_q + GenOne;
                        tick_d = 1'b1;
                    end
`else
                    cur_d  = next_gen;
                    gen_d  = gen_q + GenOne;
                    tick_d = 1'b1;
`endif
                end else begin
                    pre_d = pre_q + PreOne;
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PAUSE;
            pre_q   <= '0;
            cur_q   <= '0;
            gen_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cur_q   <= cur_d;
            gen_q   <= gen_d;
            tick_q  <= tick_d;
        end
    end

`ifdef ECA_HALT_ON_STABLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

endmodule

// File: tb/tb_eca_engine.sv
// Directed self-checking bench for eca_engine; a second instance with GEN_W=4 shares
// the stimulus to exercise generation-counter wrap.
module tb_eca_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rule;
    logic [1:0]  mode;
    logic [7:0]  period;
    logic        run;
    logic        step;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [15:0] cur;
    logic [15:0] gen_count;
    logic        tick;
    logic        stable;
    logic        load_ready4;
    logic [15:0] cur4;
    logic [3:0]  gen_count4;
    logic        tick4;
    logic        stable4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eca_engine #(.WIDTH(16), .DIV_W(8), .GEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rule_i       (rule),
        .mode_i       (mode),
        .period_i     (period),
        .run_i        (run),
        .step_i       (step),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_ready_o (load_ready),
        .cur_o        (cur),
        .gen_count_o  (gen_count),
        .tick_o       (tick),
        .stable_o     (stable)
    );

    eca_engine #(.WIDTH(16), .DIV_W(8), .GEN_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .rule_i       (rule),
        .mode_i       (mode),
        .period_i     (period),
        .run_i        (run),
        .step_i       (step),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_ready_o (load_ready4),
        .cur_o        (cur4),
        .gen_count_o  (gen_count4),
        .tick_o       (tick4),
        .stable_o     (stable4)
    );

    // One rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rule = 8'd0; mode = 2'd0; period = 8'd0; run = 1'b0; step = 1'b0;
        load_valid = 1'b0; load_data = 16'h0;
        #12;
        checks++;
        if (cur !== 16'h0 || gen_count !== 16'h0 || tick !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: cur=%h gen=%0d tick=%b ready=%b expected 0/0/0/1",
                     cur, gen_count, tick, load_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_rule90_modes();
        logic [15:0] exp_cur [4];
        exp_cur[0] = 16'h8002; exp_cur[1] = 16'h0002; exp_cur[2] = 16'h8003; exp_cur[3] = 16'h0003;
        rule = 8'd90;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            do_load(16'h0001);
            checks++;
            if (cur !== 16'h0001 || gen_count !== 16'd0 || tick !== 1'b0) begin
                failures++;
                $display("FAIL load_m%0d: cur=%h gen=%0d tick=%b expected 0001/0/0",
                         m, cur, gen_count, tick);
            end
            step = 1'b1;
            cyc();
            step = 1'b0;
            checks++;
            if (cur !== exp_cur[m] || gen_count !== 16'd1 || tick !== 1'b1) begin
                failures++;
                $display("FAIL step90_m%0d: cur=%h gen=%0d tick=%b expected %h/1/1",
                         m, cur, gen_count, tick, exp_cur[m]);
            end
            cyc();
            checks++;
            if (tick !== 1'b0 || cur !== exp_cur[m]) begin
                failures++;
                $display("FAIL tick_pulse_m%0d: tick=%b cur=%h expected 0/%h",
                         m, tick, cur, exp_cur[m]);
            end
        end
    endtask

    task automatic test_rule30_load_step();
        rule = 8'd30; mode = 2'd0;
        do_load(16'h0100);
        step = 1'b1;
        cyc();
        step = 1'b0;
        checks++;
        if (cur !== 16'h0380 || gen_count !== 16'd1 || tick !== 1'b1) begin
            failures++;
            $display("FAIL step30: cur=%h gen=%0d tick=%b expected 0380/1/1", cur, gen_count, tick);
        end
        step = 1'b1;
        do_load(16'h0100);
        step = 1'b0;
        checks++;
        if (cur !== 16'h0100 || gen_count !== 16'd0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL load_beats_step: cur=%h gen=%0d tick=%b expected 0100/0/0",
                     cur, gen_count, tick);
        end
    endtask

    task automatic test_prescaler();
        int ticks = 0;
        int last  = -1;
        int gap_err = 0;
        rule = 8'd90; mode = 2'd0; period = 8'd3;
        do_load(16'h0001);
        run = 1'b1;
        cyc();
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_entry: ready=%b expected 0", load_ready);
        end
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (tick === 1'b1) begin
                ticks++;
                if ((c % 4) != 0) gap_err++;
                last = c;
            end
        end
        checks++;
        if (ticks != 5 || gap_err != 0 || gen_count !== 16'd5) begin
            failures++;
            $display("FAIL prescale: ticks=%0d offphase=%0d gen=%0d expected 5/0/5",
                     ticks, gap_err, gen_count);
        end
        run = 1'b0;
        cyc();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL pause_ready: ready=%b expected 1", load_ready);
        end
        ticks = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (tick !== 1'b0) ticks++;
        end
        checks++;
        if (ticks != 0 || gen_count !== 16'd5) begin
            failures++;
            $display("FAIL paused_quiet: ticks=%0d gen=%0d expected 0/5", ticks, gen_count);
        end
    endtask

    task automatic test_stable();
        rule = 8'd204; mode = 2'd0; period = 8'd0;
        do_load(16'hA5A5);
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL stable_flag: stable=%b expected 1", stable);
        end
        run = 1'b1;
        cyc();
        cyc();
`ifdef ECA_HALT_ON_STABLE_EN
        checks++;
        if (load_ready !== 1'b1 || gen_count !== 16'd0 || tick !== 1'b0 || cur !== 16'hA5A5) begin
            failures++;
            $display("FAIL halt: ready=%b gen=%0d tick=%b cur=%h expected 1/0/0/a5a5",
                     load_ready, gen_count, tick, cur);
        end
        cyc();
        checks++;
        if (load_ready !== 1'b1 || tick !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold: ready=%b tick=%b expected 1/0", load_ready, tick);
        end
`else
        checks++;
        if (tick !== 1'b1 || gen_count !== 16'd1 || cur !== 16'hA5A5) begin
            failures++;
            $display("FAIL fixed_point_run: tick=%b gen=%0d cur=%h expected 1/1/a5a5",
                     tick, gen_count, cur);
        end
        cyc();
        checks++;
        if (tick !== 1'b1 || gen_count !== 16'd2 || cur !== 16'hA5A5) begin
            failures++;
            $display("FAIL fixed_point_run2: tick=%b gen=%0d cur=%h expected 1/2/a5a5",
                     tick, gen_count, cur);
        end
`endif
        run = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        rule = 8'd90; mode = 2'd0; period = 8'd3;
        do_load(16'h0001);
        run = 1'b1;
        cyc();
        for (int c = 0; c < 6; c++) cyc();
        checks++;
        if (gen_count !== 16'd1 || cur !== 16'h8002) begin
            failures++;
            $display("FAIL pre_reset_gen: gen=%0d cur=%h expected 1/8002", gen_count, cur);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cur !== 16'h0 || gen_count !== 16'd0 || tick !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: cur=%h gen=%0d tick=%b ready=%b expected 0/0/0/1",
                     cur, gen_count, tick, load_ready);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_gen_wrap();
        rule = 8'd90; mode = 2'd0; period = 8'd0;
        run = 1'b1;
        do_load(16'h0001);
        checks++;
        if (cur !== 16'h0001 || load_ready !== 1'b0 || gen_count !== 16'd0) begin
            failures++;
            $display("FAIL load_with_run: cur=%h ready=%b gen=%0d expected 0001/0/0",
                     cur, load_ready, gen_count);
        end
        for (int c = 0; c < 16; c++) cyc();
        checks++;
        if (gen_count4 !== 4'd0 || gen_count !== 16'd16) begin
            failures++;
            $display("FAIL wrap16: gen4=%0d gen=%0d expected 0/16", gen_count4, gen_count);
        end
        cyc();
        checks++;
        if (gen_count4 !== 4'd1 || gen_count !== 16'd17 || tick4 !== 1'b1) begin
            failures++;
            $display("FAIL wrap17: gen4=%0d gen=%0d tick4=%b expected 1/17/1",
                     gen_count4, gen_count, tick4);
        end
        run = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_rule90_modes();
        test_rule30_load_step();
        test_prescaler();
        test_stable();
        test_async_reset();
        test_gen_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eca_engine.md
Name: eca_engine

Overview:
Parametrised elementary (1-D, radius-1) cellular automaton engine of WIDTH cells. It applies an 8-bit Wolfram rule with a selectable boundary mode. Stepping is paced by a programmable prescaler or by single-step pulses. The seed is loaded through a valid/ready handshake. It is the successor of the fixed 16-cell, fixed-divider, wrap-only automaton and feeds display/LED and pattern-generator logic.

Parameters:
WIDTH, 16, number of cells (>= 3)
DIV_W, 8, prescaler width; generation period is period+1 clocks
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rule  in  8  Wolfram rule; bit index = {cur[i+1], cur[i], cur[i-1]}
mode  in  2  boundary: 00 wrap, 01 zero, 10 one, 11 mirror (missing neighbour = edge cell itself)
period  in  DIV_W  clocks between generations minus one
run  in  1  level; 1 = free-run, 0 = pause
step  in  1  single-cycle pulse; advance one generation while paused
load_valid  in  1  seed offered
load_data  in  WIDTH  seed value
load_ready  out  1  seed accepted when load_valid & load_ready
cur  out  WIDTH  current generation (registered)
gen_count  out  GEN_W  generations since last load, wraps
tick  out  1  one-cycle pulse, high the cycle after cur updates
stable  out  1  combinational; next generation == cur

Behaviour:
- Reset: cur=0, gen_count=0, tick=0, prescaler=0, state=PAUSE, load_ready=1.
- States:
  - PAUSE: load_ready=1. run=1 -> RUN and prescaler cleared.
  - RUN: load_ready=0. run=0 -> PAUSE; prescaler holds its value and is cleared again on re-entry.
- RUN: prescaler counts 0..period. On the cycle prescaler==period: cur<=next, gen_count+=1, prescaler<=0. period=0 updates every clock. period changed mid-count: compared live; if prescaler>period it counts on to wrap-around at 2^DIV_W, then matches.
- PAUSE + step=1: cur<=next and gen_count+=1 on that edge. step is ignored in RUN.
- Load handshake (PAUSE only): cur<=load_data, gen_count<=0, prescaler<=0, no tick.
  - Load and step in the same cycle: load wins, step dropped.
  - Load and run rising in the same cycle: load taken, state -> RUN on that same edge.
- tick: registered, asserted the cycle after each update, including step updates. Never asserted for a load.
- Neighbourhood for cell i: left=cur[i+1], right=cur[i-1]. Out-of-range index resolved by mode:
  - wrap: modulo WIDTH.
  - zero/one: constant.
  - mirror: cur[WIDTH-1] for the left edge, cur[0] for the right edge.
- rule, mode and period are sampled live on the update edge; no shadowing.
- gen_count wraps from 2^GEN_W-1 to 0 silently.
- rst mid-generation: everything returns to reset values at once. The next load is required before a meaningful run.

Optional Feature:
Macro ECA_HALT_ON_STABLE_EN.
- Defined: in RUN, at an update point where stable=1, cur and gen_count are left unchanged, no tick, and state forces PAUSE. The engine stays in PAUSE until run is deasserted and reasserted, or a load occurs. Step updates never force a halt.
- Undefined: stable is status-only; a fixed point keeps generating updates and ticks.

Decomposition:
- Package eca_pkg:
  - boundary-mode enum (BND_WRAP, BND_ZERO, BND_ONE, BND_MIRROR)
  - state enum (ST_PAUSE, ST_RUN)
- Sub-module eca_next_gen: purely combinational, WIDTH-parameterised; takes rule, mode and cur, produces next. It is reused by stable and by the engine.

Test Plan:
1. WIDTH=16, mode=wrap, rule=90, load 0x0001, pulse step -> cur=0x8002, gen_count=1, tick one cycle later. Repeat with mode=zero -> 0x0002; with mode=mirror -> 0x0003.
2. rule=30, wrap, load 0x0100, step -> cur=0x0380. Load again with step asserted in the same cycle -> cur=0x0100, gen_count=0, no tick.
3. period=3, run=1 for 20 clocks -> tick every 4th clock, gen_count=5. Drop run -> load_ready=1 next cycle, no further ticks.
4. rule=204 (identity), load 0xA5A5, run=1 -> stable=1.
   - Without macro: ticks continue, cur stays 0xA5A5.
   - With ECA_HALT_ON_STABLE_EN: first update point -> state PAUSE, gen_count=0, no tick.
5. Assert rst mid-run at prescaler=2 -> cur=0, gen_count=0, tick=0, load_ready=1 immediately (asynchronous).
6. GEN_W=4, period=0, 17 generations -> gen_count wraps 15->0, reads 1 at the end.
